// File: rtl/disp_4dig_scan_if.sv
// Display-side bus of the 4-digit scan driver: BCD/decimal-point/blank requests in,
// active-low anode/segment/decimal-point pins out.
interface disp_4dig_scan_if;
  logic [15:0] DEC;
  logic [3:0]  DP_IN;
  logic        BLANK;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  modport master (output DEC, DP_IN, BLANK, input AN, SEG, DP);
  modport slave  (input DEC, DP_IN, BLANK, output AN, SEG, DP);
endinterface

// File: rtl/disp_4dig_scan.sv
// Multiplexed 4-digit 7-segment driver: per-frame BCD snapshot, prescaled scan 3->2->1->0.
// Define DISP_LZ_BLANK_EN to enable leading-zero blanking of digits 3..1.
module disp_4dig_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  disp_4dig_scan_if.slave    bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [1:0]       dig_q,  dig_d;
  logic [15:0]      snap_q, snap_d;
  logic [3:0]       an_q,   an_d;
  logic [6:0]       seg_q,  seg_d;
  logic             dp_q,   dp_d;

  logic        tick;
  logic        wrap;
  logic [1:0]  dig_nx;
  logic [15:0] src;
  logic [3:0]  nib;
  logic        lz_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0:    seg_decode = 7'h40;
      4'h1:    seg_decode = 7'h79;
      4'h2:    seg_decode = 7'h24;
      4'h3:    seg_decode = 7'h30;
      4'h4:    seg_decode = 7'h19;
      4'h5:    seg_decode = 7'h12;
      4'h6:    seg_decode = 7'h02;
      4'h7:    seg_decode = 7'h78;
      4'h8:    seg_decode = 7'h00;
      4'h9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  assign tick   = ce && (cnt_q == CNT_MAX);
  assign wrap   = (dig_q == 2'd0);
  assign dig_nx = dig_q - 2'd1;
  // On the frame-start tick the incoming bus stands in for the snapshot it is about to become.
  assign src    = wrap ? bus.DEC : snap_q;
  assign nib    = src[{dig_nx, 2'b00} +: 4];

`ifdef DISP_LZ_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    case (dig_nx)
      2'd3:    lz_blank = (src[15:12] == 4'h0);
      2'd2:    lz_blank = (src[15:8]  == 8'h00);
      2'd1:    lz_blank = (src[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    dig_d  = dig_q;
    snap_d = snap_q;
    an_d   = an_q;
    seg_d  = seg_q;
    dp_d   = dp_q;
    if (ce) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    if (tick) begin
      dig_d = dig_nx;
      if (wrap) begin
        snap_d = bus.DEC;
      end
      an_d = 4'hF;
      if (!lz_blank) begin
        an_d[dig_nx] = 1'b0;
      end
      seg_d = seg_decode(nib);
      dp_d  = lz_blank | ~bus.DP_IN[dig_nx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dig_q  <= 2'd0;
      snap_q <= 16'h0000;
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  // BLANK bypasses the registers so it takes effect in the same cycle.
  assign bus.AN  = an_q | {4{bus.BLANK}};
  assign bus.SEG = seg_q;
  assign bus.DP  = dp_q | bus.BLANK;

endmodule

// File: tb/tb_disp_4dig_scan.sv
// Directed bench for disp_4dig_scan with SCAN_DIV=4: frame table plus ce, BLANK and reset sequences.
module tb_disp_4dig_scan;

  logic clk;
  logic rst_n;
  logic ce;

  disp_4dig_scan_if bus ();

  disp_4dig_scan #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dec;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t tbl [12];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] last_an;
    int         chg_cyc[$];
    logic [3:0] chg_an[$];
    logic [3:0] exp_an [4];
    logic [3:0] prev_an;

    tbl[0]  = '{16'h1234, 4'b0000, 4'b0111, 7'h79, 1'b1};
    tbl[1]  = '{16'h1234, 4'b0000, 4'b1011, 7'h24, 1'b1};
    tbl[2]  = '{16'h5678, 4'b0000, 4'b1101, 7'h30, 1'b1};
    tbl[3]  = '{16'h5678, 4'b0000, 4'b1110, 7'h19, 1'b1};
    tbl[4]  = '{16'h5678, 4'b0000, 4'b0111, 7'h12, 1'b1};
    tbl[5]  = '{16'h5678, 4'b0000, 4'b1011, 7'h02, 1'b1};
    tbl[6]  = '{16'h5678, 4'b0000, 4'b1101, 7'h78, 1'b1};
    tbl[7]  = '{16'h5678, 4'b0000, 4'b1110, 7'h00, 1'b1};
`ifdef DISP_LZ_BLANK_EN
    tbl[8]  = '{16'h0A07, 4'b0100, 4'b1111, 7'h40, 1'b1};
`else
    tbl[8]  = '{16'h0A07, 4'b0100, 4'b0111, 7'h40, 1'b1};
`endif
    tbl[9]  = '{16'h0A07, 4'b0100, 4'b1011, 7'h3F, 1'b0};
    tbl[10] = '{16'h0A07, 4'b0100, 4'b1101, 7'h40, 1'b1};
    tbl[11] = '{16'h0A07, 4'b0100, 4'b1110, 7'h78, 1'b1};

    rst_n     = 1'b0;
    ce        = 1'b1;
    bus.DEC   = 16'h1234;
    bus.DP_IN = 4'h0;
    bus.BLANK = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_AN",  {12'h0, bus.AN},  16'h000F);
    chk("rst_SEG", {9'h0, bus.SEG},  16'h007F);
    chk("rst_DP",  {15'h0, bus.DP},  16'h0001);
    rst_n = 1'b1;

    // Frame table: each slot is 4 clocks; the previous digit must still be shown one clock before the tick.
    prev_an = 4'hF;
    for (int i = 0; i < 12; i++) begin
      bus.DEC   = tbl[i].dec;
      bus.DP_IN = tbl[i].dp_in;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold_AN[%0d]", i), {12'h0, bus.AN}, {12'h0, prev_an});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("AN[%0d]", i),  {12'h0, bus.AN}, {12'h0, tbl[i].an});
      chk($sformatf("SEG[%0d]", i), {9'h0, bus.SEG}, {9'h0, tbl[i].seg});
      chk($sformatf("DP[%0d]", i),  {15'h0, bus.DP}, {15'h0, tbl[i].dp});
      prev_an = tbl[i].an;
    end

    // ce high one cycle in three: slots stretch to 12 clocks, order unchanged.
    bus.DEC   = 16'h1234;
    bus.DP_IN = 4'h0;
    reset_dut();
    last_an = bus.AN;
    for (int i = 0; i < 60; i++) begin
      ce = (i % 3 == 0);
      @(posedge clk);
      @(negedge clk);
      if (bus.AN !== last_an) begin
        chg_cyc.push_back(i);
        chg_an.push_back(bus.AN);
        last_an = bus.AN;
      end
    end
    ce = 1'b1;
    exp_an[0] = 4'b0111;
    exp_an[1] = 4'b1011;
    exp_an[2] = 4'b1101;
    exp_an[3] = 4'b1110;
    chk("ce_nchg", 16'(chg_cyc.size()), 16'd5);
    if (chg_cyc.size() > 0) chk("ce_first", 16'(chg_cyc[0]), 16'd9);
    for (int k = 0; k < 4; k++) begin
      if (chg_an.size() > k) chk($sformatf("ce_AN[%0d]", k), {12'h0, chg_an[k]}, {12'h0, exp_an[k]});
      if (chg_cyc.size() > k + 1)
        chk($sformatf("ce_len[%0d]", k), 16'(chg_cyc[k+1] - chg_cyc[k]), 16'd12);
    end

    // BLANK for 5 cycles starting mid digit-2 slot.
    bus.DP_IN = 4'hF;
    reset_dut();
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("blk_pre_AN", {12'h0, bus.AN}, 16'h000B);
    bus.BLANK = 1'b1;
    #1;
    chk("blk_AN", {12'h0, bus.AN}, 16'h000F);
    chk("blk_DP", {15'h0, bus.DP}, 16'h0001);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("blk_hold_AN[%0d]", c), {12'h0, bus.AN}, 16'h000F);
    end
    bus.BLANK = 1'b0;
    #1;
    chk("blk_rel_AN",  {12'h0, bus.AN}, 16'h000D);
    chk("blk_rel_SEG", {9'h0, bus.SEG}, 16'h0030);
    chk("blk_rel_DP",  {15'h0, bus.DP}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("blk_next_AN", {12'h0, bus.AN}, 16'h000E);

    // Asynchronous reset between edges while digit 1 is lit.
    bus.DP_IN = 4'h0;
    reset_dut();
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("ar_pre_AN", {12'h0, bus.AN}, 16'h000D);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_AN",  {12'h0, bus.AN}, 16'h000F);
    chk("ar_SEG", {9'h0, bus.SEG}, 16'h007F);
    chk("ar_DP",  {15'h0, bus.DP}, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ar_wait_AN", {12'h0, bus.AN}, 16'h000F);
    @(posedge clk);
    @(negedge clk);
    chk("ar_restart_AN",  {12'h0, bus.AN}, 16'h0007);
    chk("ar_restart_SEG", {9'h0, bus.SEG}, 16'h0079);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
